// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared definitions for the main-RAM arbiter: CPU access FSM state codes,
// grant encoding, and a helper that turns the video burst parameter into the
// 4-bit streak limit.
package ram_arbiter_pkg;

    // CPU access FSM state codes
    typedef logic [1:0] cpu_state_t;
    localparam cpu_state_t C_IDLE   = 2'd0;
    localparam cpu_state_t C_ISSUED = 2'd1;
    localparam cpu_state_t C_DONE   = 2'd2;

    // Which requester owns the RAM slot this cycle
    typedef logic [1:0] gnt_t;
    localparam gnt_t GNT_NONE = 2'd0;
    localparam gnt_t GNT_CPU  = 2'd1;
    localparam gnt_t GNT_VID  = 2'd2;

    // Clamp the burst limit into the 1..15 range the 4-bit streak counter can hold
    function automatic logic [3:0] streak_limit(input int burst);
        if (burst < 1) begin
            return 4'd1;
        end
        if (burst > 15) begin
            return 4'd15;
        end
        return 4'(burst);
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares the single-port main RAM between the Z80 CPU and the text-mode video
// fetcher. One RAM slot per clock; the CPU is stalled via cpu_wait_n until its
// slot completes; video wins contention but only for VID_BURST consecutive
// slots while the CPU is waiting, so the CPU cannot starve.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata CPU RAM request (level), write flag, address, data
//   cpu_rdata, cpu_wait_n CPU read data, stall (low = wait)
//   vid_req, vid_addr     video fetch request (held until granted), address
//   vid_gnt               video slot granted this cycle
//   vid_valid, vid_rdata  video read data, valid the cycle after vid_gnt
//   ram_addr/we/wdata     RAM command (all zero when no grant)
//   ram_rdata             RAM read data, one cycle after the address
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int VID_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_wait_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [3:0] BURST_MAX = streak_limit(VID_BURST);

    cpu_state_t        state_reg, state_next;
    logic [3:0]        streak_reg, streak_next;
    logic [DATA_W-1:0] hold_reg, hold_next;
    logic              issued_we_reg;   // direction of the access now in C_ISSUED
    logic              vid_valid_reg;
    logic              cpu_elig;
    gnt_t              gnt;

    // The CPU may only start a new access from C_IDLE; a held mreq parked in
    // C_DONE must not issue again.
    assign cpu_elig = cpu_req && (state_reg == C_IDLE);

    // Priority: video first, unless it has already used its full burst while
    // the CPU was waiting.
    always_comb begin
        gnt = GNT_NONE;
        if (cpu_elig && vid_req) begin
            gnt = (streak_reg == BURST_MAX) ? GNT_CPU : GNT_VID;
        end else if (cpu_elig) begin
            gnt = GNT_CPU;
        end else if (vid_req) begin
            gnt = GNT_VID;
        end
    end

    // Streak only measures how long an eligible CPU has been passed over.
    always_comb begin
        streak_next = streak_reg;
        if (!cpu_elig || gnt == GNT_CPU) begin
            streak_next = 4'd0;
        end else if (gnt == GNT_VID) begin
            streak_next = streak_reg + 4'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        case (state_reg)
            C_IDLE: begin
                if (gnt == GNT_CPU) begin
                    state_next = C_ISSUED;
                end
            end
            C_ISSUED: begin
                if (!issued_we_reg) begin
                    hold_next = ram_rdata;
                end
                state_next = cpu_req ? C_DONE : C_IDLE;
            end
            C_DONE: begin
                if (!cpu_req) begin
                    state_next = C_IDLE;
                end
            end
            default: state_next = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= C_IDLE;
            streak_reg    <= 4'd0;
            hold_reg      <= '0;
            issued_we_reg <= 1'b0;
            vid_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            streak_reg    <= streak_next;
            hold_reg      <= hold_next;
            vid_valid_reg <= (gnt == GNT_VID);
            if (gnt == GNT_CPU) begin
                issued_we_reg <= cpu_we;
            end
        end
    end

    // RAM command is driven straight from the grant so the access lands in
    // the same cycle it is granted.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (gnt == GNT_CPU) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
        end else if (gnt == GNT_VID) begin
            ram_addr  = vid_addr;
        end
    end

    assign cpu_wait_n = !cpu_req || (state_reg != C_IDLE);
    assign cpu_rdata  = (state_reg == C_ISSUED && !issued_we_reg) ? ram_rdata : hold_reg;
    assign vid_gnt    = (gnt == GNT_VID);
    assign vid_valid  = vid_valid_reg;
    assign vid_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed stimulus with a scoreboard: expected CPU read data and video fetch
// data are queued as transactions are issued; a negedge monitor pops and
// compares whenever the DUT completes a CPU access or raises vid_valid.
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait_n;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_gnt;
    logic        vid_valid;
    logic [7:0]  vid_rdata;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    typedef struct packed {
        logic       rd;
        logic [7:0] data;
    } cpu_exp_t;

    cpu_exp_t   cpu_exp[$];
    logic [7:0] vid_exp[$];

    int checks = 0;
    int passes = 0;

    ram_arbiter #(
        .ADDR_W(16),
        .DATA_W(8),
        .VID_BURST(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_wait_n(cpu_wait_n),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_gnt   (vid_gnt),
        .vid_valid (vid_valid),
        .vid_rdata (vid_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: preset contents come from a function, written bytes from the array.
    logic [7:0] mem     [0:65535];
    logic       written [0:65535];

    function automatic logic [7:0] preset(input logic [15:0] a);
        if (a == 16'h8123) return 8'hA5;
        if (a[15:4] == 12'hF00) return 8'h60 + {4'h0, a[3:0]};
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
        if (written[ram_addr] === 1'b1) ram_rdata <= mem[ram_addr];
        else                             ram_rdata <= preset(ram_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: CPU completion is the first wait-released cycle of a request
    // that was stalled the cycle before.
    logic prev_req    = 1'b0;
    logic prev_wait_n = 1'b1;

    always @(negedge clk) begin
        if (cpu_req && cpu_wait_n && prev_req && !prev_wait_n) begin
            if (cpu_exp.size() == 0) begin
                check("cpu_unexpected_done", 1, 0);
            end else begin
                cpu_exp_t e;
                e = cpu_exp.pop_front();
                if (e.rd) begin
                    $display("cpu read  done  data=%02h", cpu_rdata);
                    check("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, e.data});
                end else begin
                    $display("cpu write done");
                end
            end
        end
        prev_req    = cpu_req;
        prev_wait_n = cpu_wait_n;
        if (vid_gnt) begin
            check("vid_gnt_ram_cmd", {15'h0, ram_we, ram_addr}, {16'h0, vid_addr});
        end
        if (vid_valid) begin
            if (vid_exp.size() == 0) begin
                check("vid_unexpected_valid", 1, 0);
            end else begin
                logic [7:0] d;
                d = vid_exp.pop_front();
                $display("vid fetch done  data=%02h", vid_rdata);
                check("vid_rdata", {24'h0, vid_rdata}, {24'h0, d});
            end
        end
    end

    // Continuous video plus one CPU read: 4 video slots, then the CPU.
    task automatic contention();
        int  k, vg, vg_before, wl;
        bit  saw_cpu, done, bump;
        k = 0; vg = 0; vg_before = -1; wl = 0; saw_cpu = 0; done = 0;
        cpu_exp.push_back('{rd: 1'b1, data: 8'hA5});
        cpu_addr = 16'h8123; cpu_we = 1'b0; cpu_req = 1'b1;
        vid_req = 1'b1; vid_addr = 16'hF000;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (vid_gnt) begin
                vid_exp.push_back(8'h60 + k[7:0]);
                vg++;
            end
            if (!cpu_wait_n) wl++;
            if (!saw_cpu && !cpu_wait_n && !vid_gnt && ram_addr == 16'h8123) begin
                saw_cpu   = 1;
                vg_before = vg;
            end
            if (saw_cpu && cpu_wait_n) done = 1;
            if (!done) begin
                bump = vid_gnt;
                tick();
                if (bump) k++;
                vid_addr = 16'hF000 + k[15:0];
            end
        end
        check("contend_cpu_done", {31'h0, done}, 1);
        check("contend_vid_grants", vg_before, 4);
        check("contend_wait_cycles", wl, 5);
        tick();
        cpu_req = 1'b0; vid_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int we_cnt;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'h00;
            written[i] = 1'b0;
        end
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0;
        #2;
        check("rst_wait_n", {31'h0, cpu_wait_n}, 1);
        check("rst_vid_gnt", {31'h0, vid_gnt}, 0);
        check("rst_vid_valid", {31'h0, vid_valid}, 0);
        check("rst_ram_cmd", {7'h0, ram_we, ram_wdata, ram_addr}, 0);
        check("rst_cpu_rdata", {24'h0, cpu_rdata}, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // CPU read alone, then held for 3 more cycles
        cpu_exp.push_back('{rd: 1'b1, data: 8'hA5});
        cpu_addr = 16'h8123; cpu_we = 1'b0; cpu_req = 1'b1;
        @(negedge clk);
        check("rd_stall", {31'h0, cpu_wait_n}, 0);
        check("rd_addr", {16'h0, ram_addr}, 32'h8123);
        tick();
        @(negedge clk);
        check("rd_released", {31'h0, cpu_wait_n}, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("rd_no_reissue", {31'h0, (ram_addr == 16'h8123)}, 0);
            check("rd_held_wait_n", {31'h0, cpu_wait_n}, 1);
        end
        tick();
        cpu_req = 1'b0;
        tick();

        // CPU write: one ram_we pulse, then read it back
        cpu_exp.push_back('{rd: 1'b0, data: 8'h00});
        cpu_addr = 16'h9000; cpu_wdata = 8'h3C; cpu_we = 1'b1; cpu_req = 1'b1;
        we_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) check("wr_stall", {31'h0, cpu_wait_n}, 0);
            we_cnt += int'(ram_we);
            tick();
        end
        check("wr_we_pulses", we_cnt, 1);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
        tick();
        cpu_exp.push_back('{rd: 1'b1, data: 8'h3C});
        cpu_addr = 16'h9000; cpu_req = 1'b1;
        tick(); tick(); tick();
        cpu_req = 1'b0;
        tick();

        // Video streaming: one grant per cycle
        vid_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            vid_addr = 16'hF000 + 16'(i);
            @(negedge clk);
            check("vid_stream_gnt", {31'h0, vid_gnt}, 1);
            if (vid_gnt) vid_exp.push_back(8'h60 + 8'(i));
            tick();
        end
        vid_req = 1'b0;
        tick(); tick();

        // Contention, twice: the second run shows the streak was cleared
        contention();
        contention();

        // Back-to-back CPU reads with one idle request cycle between them
        cpu_exp.push_back('{rd: 1'b1, data: 8'hA5});
        cpu_addr = 16'h8123; cpu_req = 1'b1;
        @(negedge clk);
        check("b2b_first_gnt", {31'h0, cpu_wait_n}, 0);
        tick();
        @(negedge clk);
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        tick();
        cpu_exp.push_back('{rd: 1'b1, data: 8'h3C});
        cpu_addr = 16'h9000; cpu_req = 1'b1;
        @(negedge clk);
        check("b2b_second_gnt", {15'h0, cpu_wait_n, ram_addr}, 32'h9000);
        tick();
        @(negedge clk);
        tick();
        cpu_req = 1'b0;
        tick();

        // Reset asserted during the C_ISSUED cycle, with a video grant in flight
        cpu_addr = 16'h9000; cpu_we = 1'b0; cpu_req = 1'b1;
        @(negedge clk);
        check("rstmid_gnt", {31'h0, cpu_wait_n}, 0);
        tick();
        vid_req = 1'b1; vid_addr = 16'hF001;
        #1;
        rst_n = 1'b0; cpu_req = 1'b0; vid_req = 1'b0;
        #1;
        check("rstmid_vid_valid", {31'h0, vid_valid}, 0);
        check("rstmid_wait_n", {31'h0, cpu_wait_n}, 1);
        check("rstmid_cpu_rdata", {24'h0, cpu_rdata}, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstmid_no_valid", {31'h0, vid_valid}, 0);
        end
        tick();

        check("cpu_queue_empty", cpu_exp.size(), 0);
        check("vid_queue_empty", vid_exp.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port 64K main RAM between the Z80 CPU and the text-mode video fetcher. Sits between the CPU address decode (RAM chip-select) and the block-RAM instance. Grants one RAM slot per clock, stretches the CPU cycle with `cpu_wait_n`, and caps video priority so the CPU cannot starve.

## Interface
- `ADDR_W`, 16, RAM address width
- `DATA_W`, 8, RAM data width
- `VID_BURST`, 4, max consecutive video grants while a CPU access is pending (1..15)

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU RAM access request (mreq decoded for RAM), level
- `cpu_we`  in  1  1 = write, 0 = read; valid with `cpu_req`
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_rdata`  out  DATA_W  CPU read data
- `cpu_wait_n`  out  1  low = stall CPU
- `vid_req`  in  1  video fetch request, level, held until granted
- `vid_addr`  in  ADDR_W  video fetch address
- `vid_gnt`  out  1  video request accepted this cycle
- `vid_valid`  out  1  `vid_rdata` valid (cycle after `vid_gnt`)
- `vid_rdata`  out  DATA_W  video read data
- `ram_addr`  out  ADDR_W  RAM address
- `ram_we`  out  1  RAM write enable
- `ram_wdata`  out  DATA_W  RAM write data
- `ram_rdata`  in  DATA_W  RAM read data, 1-cycle synchronous read latency

## Operation
- CPU FSM: C_IDLE, C_ISSUED, C_DONE.
  - C_IDLE: CPU eligible when `cpu_req`=1. On CPU grant -> C_ISSUED.
  - C_ISSUED (one cycle): access complete; `cpu_rdata` = `ram_rdata`, captured into hold register. -> C_DONE if `cpu_req` still high, else C_IDLE.
  - C_DONE: no new CPU access until `cpu_req` drops; then -> C_IDLE. Prevents re-issuing a held Z80 mreq.
- Arbitration each cycle, among eligible requesters (CPU eligible only in C_IDLE):
  - Only one eligible: it wins.
  - Both: video wins unless `streak` == VID_BURST, then CPU wins.
- `streak` (4-bit): +1 on each video grant while CPU eligible; cleared on CPU grant or whenever CPU is not eligible; never exceeds VID_BURST.
- RAM drive (combinational from grant): CPU grant -> `ram_addr`=`cpu_addr`, `ram_we`=`cpu_we`, `ram_wdata`=`cpu_wdata`; video grant -> `ram_addr`=`vid_addr`, `ram_we`=0; no grant -> all zero.
- `cpu_wait_n` = 1 when `cpu_req`=0 or state is C_ISSUED/C_DONE; else 0.
- `cpu_rdata` = `ram_rdata` in C_ISSUED after a read, hold register otherwise. Writes leave the hold register unchanged.
- `vid_gnt` is combinational and equals the video grant. `vid_valid` is `vid_gnt` registered. `vid_rdata` = `ram_rdata`.

## Timing
- Reset values: state C_IDLE, `streak` 0, hold register 0, `vid_valid` 0. With inputs low: `ram_*` 0, `vid_gnt` 0, `cpu_wait_n` 1.
- Reset asserted mid-access: in-flight access is dropped; no `vid_valid` after reset release for a pre-reset grant.
- CPU access:
  - Cycle N: grant.
  - Cycle N+1: `cpu_wait_n`=1, read data valid.
  - Minimum stall: one cycle (N). Worst case: VID_BURST+1 cycles.
- Video is fully pipelined. A grant is possible every cycle; `vid_valid` always follows N+1.
- Simultaneous CPU and video grant: impossible; exactly zero or one grant per cycle.
- CPU write and video read never collide on the RAM port.

## Structure
- Shared package holds the CPU FSM state enum (C_IDLE/C_ISSUED/C_DONE) and the grant encoding (GNT_NONE/GNT_CPU/GNT_VID).
- Single module, no sub-modules.
- The grant/streak logic may be split into `ram_arb_pick` (combinational priority plus streak update) only if reused for a later DMA requester.

## Test plan
- CPU read alone: `cpu_req`=1, `cpu_we`=0, `cpu_addr`=16'h8123, RAM holding 8'hA5 -> `cpu_wait_n` low 1 cycle, then high with `cpu_rdata`=8'hA5. `cpu_req` held 3 more cycles -> no further `ram_addr`=16'h8123 issue.
- CPU write: `cpu_addr`=16'h9000, `cpu_wdata`=8'h3C -> `ram_we`=1 for exactly 1 cycle; a later read returns 8'h3C.
- Video streaming: `vid_req` held, addresses 16'hF000..F00F -> 16 consecutive `vid_gnt`; `vid_valid` in each following cycle with matching data.
- Contention: continuous `vid_req` plus a CPU read, VID_BURST=4 -> exactly 4 video grants, then a CPU grant; `cpu_wait_n` low 5 cycles; `streak` returns to 0.
- Back-to-back CPU: `cpu_req` drops for 1 cycle between two reads -> second access granted the cycle `cpu_req` re-asserts and C_DONE has exited.
- Reset mid-access: `rst_n` low in the C_ISSUED cycle -> `vid_valid`=0, `cpu_wait_n`=1 with `cpu_req` low, `cpu_rdata`=0 immediately (asynchronous).
